// File: rtl/axi4_slave_bfm.sv
// AXI4 slave memory model: byte-addressed RAM behind independent write/read FSMs with optional LFSR-driven stalls.
// Optional macro AXI_BFM_OOR_SLVERR_EN: out-of-range beats are dropped/read as 0 and answered with SLVERR.
module axi4_slave_bfm #(
  parameter int          C_S_AXI_ID_WIDTH       = 4,
  parameter int          C_S_AXI_ADDR_WIDTH     = 40,
  parameter int          C_S_AXI_DATA_WIDTH     = 128,
  parameter int          C_S_AXI_AWUSER_WIDTH   = 1,
  parameter int          C_S_AXI_ARUSER_WIDTH   = 1,
  parameter int          C_S_AXI_WUSER_WIDTH    = 1,
  parameter int          C_S_AXI_RUSER_WIDTH    = 1,
  parameter int          C_S_AXI_BUSER_WIDTH    = 1,
  parameter logic [63:0] C_S_AXI_TARGET         = 64'h0,
  parameter int          C_OFFSET_WIDTH         = 20,
  parameter int          C_S_AXI_BURST_LEN      = 256,
  parameter int          WRITE_RANDOM_WAIT      = 1,
  parameter int          READ_RANDOM_WAIT       = 1,
  parameter int          READ_DATA_IS_INCREMENT = 0,
  parameter int          RANDOM_BVALID_WAIT     = 1
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [7:0]                        S_AXI_AWLEN,
  input  logic [2:0]                        S_AXI_AWSIZE,
  input  logic [1:0]                        S_AXI_AWBURST,
  input  logic                              S_AXI_AWLOCK,
  input  logic [3:0]                        S_AXI_AWCACHE,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic [3:0]                        S_AXI_AWQOS,
  input  logic [C_S_AXI_AWUSER_WIDTH-1:0]   S_AXI_AWUSER,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WLAST,
  input  logic [C_S_AXI_WUSER_WIDTH-1:0]    S_AXI_WUSER,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_BID,
  output logic [1:0]                        S_AXI_BRESP,
  output logic [C_S_AXI_BUSER_WIDTH-1:0]    S_AXI_BUSER,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [7:0]                        S_AXI_ARLEN,
  input  logic [2:0]                        S_AXI_ARSIZE,
  input  logic [1:0]                        S_AXI_ARBURST,
  input  logic                              S_AXI_ARLOCK,
  input  logic [3:0]                        S_AXI_ARCACHE,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic [3:0]                        S_AXI_ARQOS,
  input  logic [C_S_AXI_ARUSER_WIDTH-1:0]   S_AXI_ARUSER,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RLAST,
  output logic [C_S_AXI_RUSER_WIDTH-1:0]    S_AXI_RUSER,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY
);

  localparam int AW    = C_S_AXI_ADDR_WIDTH;
  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int NB    = DW / 8;
  localparam int BW    = $clog2(NB);
  localparam int WORDW = C_OFFSET_WIDTH - BW;
  localparam int DEPTH = 2 ** WORDW;

  localparam logic [AW-1:0] TARGET  = AW'(C_S_AXI_TARGET);
  localparam logic [8:0]    MAX_LEN = 9'(C_S_AXI_BURST_LEN - 1);
  localparam logic [1:0]    OKAY    = 2'b00;
  localparam logic [1:0]    SLVERR  = 2'b10;
  localparam logic [15:0]   W_SEED  = 16'hACE1;
  localparam logic [15:0]   R_SEED  = 16'h1D2B;

`ifdef AXI_BFM_OOR_SLVERR_EN
  localparam bit OOR_EN = 1'b1;
`else
  localparam bit OOR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic [2:0] size,
                                               input logic [1:0] burst);
    // WRAP is deliberately treated as INCR.
    return (burst == 2'b00) ? a : a + (AW'(1) << size);
  endfunction

  function automatic logic [7:0] clamp_len(input logic [7:0] len);
    return ({1'b0, len} > MAX_LEN) ? MAX_LEN[7:0] : len;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  logic [DW-1:0] mem [DEPTH];

  // ---------------- write side ----------------
  w_state_t                    w_state, w_next;
  logic [C_S_AXI_ID_WIDTH-1:0] w_id;
  logic [AW-1:0]               w_addr, w_off;
  logic [7:0]                  w_len, w_beat;
  logic [2:0]                  w_size, w_delay;
  logic [1:0]                  w_burst;
  logic                        w_err, w_oor, w_hs, w_stall, awready, bvalid;
  logic [15:0]                 w_lfsr;
  logic [4:0]                  w_stall_cnt;
  logic [WORDW-1:0]            w_word;

  assign w_off   = w_addr - TARGET;
  assign w_word  = w_off[C_OFFSET_WIDTH-1:BW];
  assign w_oor   = OOR_EN && (w_off[AW-1:C_OFFSET_WIDTH] != '0);
  assign w_stall = (WRITE_RANDOM_WAIT != 0) && w_lfsr[0] && (w_stall_cnt != 5'd16);
  assign w_hs    = S_AXI_WVALID && S_AXI_WREADY;

  assign S_AXI_AWREADY = awready;
  assign S_AXI_WREADY  = (w_state == W_DATA) && !w_stall;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BID     = w_id;
  assign S_AXI_BRESP   = w_err ? SLVERR : OKAY;
  assign S_AXI_BUSER   = '0;

  // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE: if (S_AXI_AWVALID && awready)                   w_next = W_DATA;
      W_DATA: if (w_hs && (w_beat == w_len || S_AXI_WLAST))   w_next = W_RESP;
      W_RESP: if (bvalid && S_AXI_BREADY)                     w_next = W_IDLE;
      default:                                                w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      w_state     <= W_IDLE;
      awready     <= 1'b0;
      bvalid      <= 1'b0;
      w_id        <= '0;
      w_addr      <= '0;
      w_len       <= '0;
      w_beat      <= '0;
      w_size      <= '0;
      w_burst     <= '0;
      w_delay     <= '0;
      w_err       <= 1'b0;
      w_lfsr      <= W_SEED;
      w_stall_cnt <= '0;
    end else begin
      w_state     <= w_next;
      awready     <= (w_next == W_IDLE);
      w_lfsr      <= lfsr_step(w_lfsr);
      w_stall_cnt <= w_stall ? w_stall_cnt + 5'd1 : 5'd0;
      unique case (w_state)
        W_IDLE: if (S_AXI_AWVALID && awready) begin
          w_id    <= S_AXI_AWID;
          w_addr  <= S_AXI_AWADDR;
          w_len   <= clamp_len(S_AXI_AWLEN);
          w_size  <= S_AXI_AWSIZE;
          w_burst <= S_AXI_AWBURST;
          w_beat  <= '0;
          w_err   <= 1'b0;
        end
        W_DATA: if (w_hs) begin
          w_addr <= next_addr(w_addr, w_size, w_burst);
          w_beat <= w_beat + 8'd1;
          if (w_oor) w_err <= 1'b1;
          w_delay <= (RANDOM_BVALID_WAIT != 0) ? w_lfsr[2:0] : 3'd0;
        end
        W_RESP: begin
          if (!bvalid) begin
            if (w_delay == 3'd0) bvalid <= 1'b1;
            else                 w_delay <= w_delay - 3'd1;
          end else if (S_AXI_BREADY) begin
            bvalid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the RAM is kept out of reset so its contents survive ARESETN and map onto plain storage.
  always_ff @(posedge ACLK) begin
    if (ARESETN && w_hs && !w_oor) begin
      for (int b = 0; b < NB; b++) begin
        if (S_AXI_WSTRB[b]) mem[w_word][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  // ---------------- read side ----------------
  r_state_t                    r_state, r_next;
  logic [C_S_AXI_ID_WIDTH-1:0] r_id;
  logic [AW-1:0]               r_addr, r_off;
  logic [7:0]                  r_len, r_beat;
  logic [2:0]                  r_size;
  logic [1:0]                  r_burst, rresp;
  logic                        r_oor, r_hs, r_stall, arready, rvalid, rlast;
  logic [15:0]                 r_lfsr;
  logic [4:0]                  r_stall_cnt;
  logic [WORDW-1:0]            r_word;
  logic [31:0]                 r_count;
  logic [DW-1:0]               rdata;

  assign r_off   = r_addr - TARGET;
  assign r_word  = r_off[C_OFFSET_WIDTH-1:BW];
  assign r_oor   = OOR_EN && (r_off[AW-1:C_OFFSET_WIDTH] != '0);
  assign r_stall = (READ_RANDOM_WAIT != 0) && r_lfsr[0] && (r_stall_cnt != 5'd16);
  assign r_hs    = rvalid && S_AXI_RREADY;

  assign S_AXI_ARREADY = arready;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RDATA   = rdata;
  assign S_AXI_RLAST   = rlast;
  assign S_AXI_RRESP   = rresp;
  assign S_AXI_RID     = r_id;
  assign S_AXI_RUSER   = '0;

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE:  if (S_AXI_ARVALID && arready) r_next = R_DATA;
      R_DATA:  if (r_hs && rlast)            r_next = R_IDLE;
      default:                               r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_state     <= R_IDLE;
      arready     <= 1'b0;
      rvalid      <= 1'b0;
      rlast       <= 1'b0;
      rdata       <= '0;
      rresp       <= OKAY;
      r_id        <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_beat      <= '0;
      r_size      <= '0;
      r_burst     <= '0;
      r_count     <= '0;
      r_lfsr      <= R_SEED;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= r_next;
      arready     <= (r_next == R_IDLE);
      r_lfsr      <= lfsr_step(r_lfsr);
      r_stall_cnt <= r_stall ? r_stall_cnt + 5'd1 : 5'd0;
      if (r_hs) r_count <= r_count + 32'd1;
      unique case (r_state)
        R_IDLE: if (S_AXI_ARVALID && arready) begin
          r_id    <= S_AXI_ARID;
          r_addr  <= S_AXI_ARADDR;
          r_len   <= clamp_len(S_AXI_ARLEN);
          r_size  <= S_AXI_ARSIZE;
          r_burst <= S_AXI_ARBURST;
          r_beat  <= '0;
        end
        R_DATA: begin
          if (r_hs && rlast) begin
            rvalid <= 1'b0;
            rlast  <= 1'b0;
          end else if (!rvalid || S_AXI_RREADY) begin
            // A presented beat is only replaced after its handshake, so RVALID/RDATA never drop early.
            if (r_stall) begin
              rvalid <= 1'b0;
            end else begin
              rvalid <= 1'b1;
              rlast  <= (r_beat == r_len);
              rresp  <= r_oor ? SLVERR : OKAY;
              r_beat <= r_beat + 8'd1;
              r_addr <= next_addr(r_addr, r_size, r_burst);
              if (r_oor)                            rdata <= '0;
              else if (READ_DATA_IS_INCREMENT != 0) rdata <= DW'(r_hs ? r_count + 32'd1 : r_count);
              else                                  rdata <= mem[r_word];
            end
          end
        end
        default: ;
      endcase
    end
  end

  logic unused_inputs;
  assign unused_inputs = &{1'b0, S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS, S_AXI_AWUSER,
                           S_AXI_WUSER, S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS,
                           S_AXI_ARUSER, w_off, r_off};

endmodule

// File: tb/tb_axi4_slave_bfm.sv
// Directed scoreboard bench for axi4_slave_bfm: one instance with random stalls, one with incrementing read data.
module tb_axi4_slave_bfm;
  localparam int IDW = 4;
  localparam int AW  = 40;
  localparam int DW  = 128;
  localparam int NB  = 16;
  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [IDW-1:0] awid, arid, bid, rid;
  logic [AW-1:0]  awaddr, araddr;
  logic [7:0]     awlen, arlen;
  logic [2:0]     awsize, arsize;
  logic [1:0]     awburst, arburst, bresp, rresp;
  logic           awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic           arvalid, arready, rlast, rvalid, rready, buser, ruser;
  logic [DW-1:0]  wdata, rdata;
  logic [NB-1:0]  wstrb;

  logic [AW-1:0]  i_araddr;
  logic [7:0]     i_arlen;
  logic           i_arvalid, i_arready, i_rready, i_rvalid, i_rlast;
  logic           i_awready, i_wready, i_bvalid, i_buser, i_ruser;
  logic [IDW-1:0] i_bid, i_rid;
  logic [1:0]     i_bresp, i_rresp;
  logic [DW-1:0]  i_rdata;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] model [int];
  logic [DW-1:0] rq [$];
  logic [DW-1:0] iq [$];
  logic [DW-1:0] wq_data [$];
  logic [NB-1:0] wq_strb [$];
  int inc_cnt = 0;

  axi4_slave_bfm u_dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
    .S_AXI_AWBURST(awburst), .S_AXI_AWLOCK(1'b0), .S_AXI_AWCACHE(4'd0), .S_AXI_AWPROT(3'd0),
    .S_AXI_AWQOS(4'd0), .S_AXI_AWUSER(1'b0), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WUSER(1'b0),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BUSER(buser), .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize),
    .S_AXI_ARBURST(arburst), .S_AXI_ARLOCK(1'b0), .S_AXI_ARCACHE(4'd0), .S_AXI_ARPROT(3'd0),
    .S_AXI_ARQOS(4'd0), .S_AXI_ARUSER(1'b0), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
    .S_AXI_RUSER(ruser), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  axi4_slave_bfm #(
    .WRITE_RANDOM_WAIT(0), .READ_RANDOM_WAIT(0), .RANDOM_BVALID_WAIT(0), .READ_DATA_IS_INCREMENT(1)
  ) u_inc (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWID(4'd0), .S_AXI_AWADDR(40'd0), .S_AXI_AWLEN(8'd0), .S_AXI_AWSIZE(3'd4),
    .S_AXI_AWBURST(INCR), .S_AXI_AWLOCK(1'b0), .S_AXI_AWCACHE(4'd0), .S_AXI_AWPROT(3'd0),
    .S_AXI_AWQOS(4'd0), .S_AXI_AWUSER(1'b0), .S_AXI_AWVALID(1'b0), .S_AXI_AWREADY(i_awready),
    .S_AXI_WDATA('0), .S_AXI_WSTRB('0), .S_AXI_WLAST(1'b0), .S_AXI_WUSER(1'b0),
    .S_AXI_WVALID(1'b0), .S_AXI_WREADY(i_wready),
    .S_AXI_BID(i_bid), .S_AXI_BRESP(i_bresp), .S_AXI_BUSER(i_buser), .S_AXI_BVALID(i_bvalid),
    .S_AXI_BREADY(1'b1),
    .S_AXI_ARID(4'd0), .S_AXI_ARADDR(i_araddr), .S_AXI_ARLEN(i_arlen), .S_AXI_ARSIZE(3'd4),
    .S_AXI_ARBURST(INCR), .S_AXI_ARLOCK(1'b0), .S_AXI_ARCACHE(4'd0), .S_AXI_ARPROT(3'd0),
    .S_AXI_ARQOS(4'd0), .S_AXI_ARUSER(1'b0), .S_AXI_ARVALID(i_arvalid), .S_AXI_ARREADY(i_arready),
    .S_AXI_RID(i_rid), .S_AXI_RDATA(i_rdata), .S_AXI_RRESP(i_rresp), .S_AXI_RLAST(i_rlast),
    .S_AXI_RUSER(i_ruser), .S_AXI_RVALID(i_rvalid), .S_AXI_RREADY(i_rready)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Default build aliases every address modulo the 1 MiB RAM (16-byte words).
  function automatic int widx(input logic [AW-1:0] a);
    return int'(a[19:4]);
  endfunction

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] a, input logic [2:0] size,
                                        input logic [1:0] burst);
    return (burst == FIXED) ? a : a + (AW'(1) << size);
  endfunction

  task automatic do_write(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    logic [AW-1:0] a;
    logic [DW-1:0] word;
    int n;
    a = addr;
    @(negedge clk);
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    n = 0;
    #1;
    while (!awready && n < 200) begin @(negedge clk); #1; n++; end
    if (n >= 200) check("aw_timeout", awready, 1);
    @(posedge clk); #1 awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      @(negedge clk);
      wdata = wq_data.pop_front(); wstrb = wq_strb.pop_front(); wlast = (i == int'(len)); wvalid = 1'b1;
      n = 0;
      #1;
      while (!wready && n < 200) begin @(negedge clk); #1; n++; end
      if (n >= 200) check("w_timeout", wready, 1);
      word = model.exists(widx(a)) ? model[widx(a)] : '0;
      for (int b = 0; b < NB; b++) if (wstrb[b]) word[8*b +: 8] = wdata[8*b +: 8];
      model[widx(a)] = word;
      @(posedge clk);
      a = nxt(a, size, burst);
    end
    #1 wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bvalid && n < 200) begin @(negedge clk); n++; end
    check("bvalid", bvalid, 1);
    check("bid", bid, id);
    check("bresp", bresp, 0);
    @(posedge clk); #1 bready = 1'b0;
  endtask

  task automatic do_read(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input bit toggle);
    logic [AW-1:0] a;
    logic [DW-1:0] pdata;
    logic plast;
    bit hold;
    int n, beats;
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      rq.push_back(model[widx(a)]);
      a = nxt(a, size, burst);
    end
    @(negedge clk);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    n = 0;
    #1;
    while (!arready && n < 200) begin @(negedge clk); #1; n++; end
    if (n >= 200) check("ar_timeout", arready, 1);
    @(posedge clk); #1 arvalid = 1'b0;
    beats = 0; n = 0; hold = 1'b0; pdata = '0; plast = 1'b0;
    while (beats <= int'(len) && n < 5000) begin
      @(negedge clk);
      rready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      #1; n++;
      if (hold) begin
        check("r_hold_valid", rvalid, 1);
        check("r_hold_data", rdata, pdata);
        check("r_hold_last", rlast, plast);
      end
      if (rvalid && rready) begin
        check("rdata", rdata, rq.pop_front());
        check("rlast", rlast, beats == int'(len));
        check("rid", rid, id);
        check("rresp", rresp, 0);
        beats++;
        hold = 1'b0;
      end else begin
        hold = rvalid; pdata = rdata; plast = rlast;
      end
    end
    if (beats <= int'(len)) check("r_timeout", beats, int'(len) + 1);
    @(posedge clk); #1 rready = 1'b0;
  endtask

  task automatic do_read_inc(input logic [7:0] len);
    int n, beats;
    for (int i = 0; i <= int'(len); i++) begin iq.push_back(DW'(inc_cnt)); inc_cnt++; end
    @(negedge clk);
    i_araddr = '0; i_arlen = len; i_arvalid = 1'b1;
    n = 0;
    #1;
    while (!i_arready && n < 200) begin @(negedge clk); #1; n++; end
    if (n >= 200) check("inc_ar_timeout", i_arready, 1);
    @(posedge clk); #1 i_arvalid = 1'b0; i_rready = 1'b1;
    beats = 0; n = 0;
    while (beats <= int'(len) && n < 200) begin
      @(negedge clk); n++;
      if (i_rvalid) begin
        check("inc_rdata", i_rdata, iq.pop_front());
        check("inc_rlast", i_rlast, beats == int'(len));
        beats++;
      end
    end
    if (beats <= int'(len)) check("inc_r_timeout", beats, int'(len) + 1);
    @(posedge clk); #1 i_rready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    awvalid = 0; wvalid = 0; wlast = 0; bready = 0; arvalid = 0; rready = 0;
    awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; wdata = 0; wstrb = 0;
    arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0;
    i_arvalid = 0; i_araddr = 0; i_arlen = 0; i_rready = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_arready", arready, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_inc_rvalid", i_rvalid, 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("idle_awready", awready, 1);
    check("idle_arready", arready, 1);

    // Basic 4-beat INCR write/read.
    for (int i = 1; i <= 4; i++) begin wq_data.push_back(DW'(i)); wq_strb.push_back('1); end
    do_write(4'd5, 40'h100, 8'd3, 3'd4, INCR);
    do_read(4'd6, 40'h100, 8'd3, 3'd4, INCR, 1'b0);

    // Single-byte strobe over a fully written word.
    wq_data.push_back(128'h0123456789abcdef_fedcba9876543210); wq_strb.push_back('1);
    do_write(4'd1, 40'h200, 8'd0, 3'd4, INCR);
    wq_data.push_back(128'hff); wq_strb.push_back(16'h0001);
    do_write(4'd2, 40'h200, 8'd0, 3'd4, INCR);
    do_read(4'd3, 40'h200, 8'd0, 3'd4, INCR, 1'b0);

    // FIXED burst: last beat wins.
    wq_data.push_back(128'hA); wq_data.push_back(128'hB); wq_data.push_back(128'hC);
    repeat (3) wq_strb.push_back('1);
    do_write(4'd4, 40'h300, 8'd2, 3'd4, FIXED);
    do_read(4'd5, 40'h300, 8'd0, 3'd4, INCR, 1'b0);

    // 256-beat burst with random RREADY.
    for (int i = 0; i < 256; i++) begin
      wq_data.push_back({$urandom, $urandom, $urandom, $urandom}); wq_strb.push_back('1);
    end
    do_write(4'd7, 40'h1000, 8'd255, 3'd4, INCR);
    do_read(4'd8, 40'h1000, 8'd255, 3'd4, INCR, 1'b1);

    // Top-of-RAM wrap and out-of-range aliasing.
    wq_data.push_back(128'h1111); wq_data.push_back(128'h2222);
    repeat (2) wq_strb.push_back('1);
    do_write(4'd9, 40'h0F_FFF0, 8'd1, 3'd4, INCR);
    do_read(4'd10, 40'h0, 8'd0, 3'd4, INCR, 1'b0);
    do_read(4'd11, 40'h10_0000_0100, 8'd0, 3'd4, INCR, 1'b0);

    // Reset in the middle of an 8-beat write burst.
    @(negedge clk);
    awid = 4'd3; awaddr = 40'h5000; awlen = 8'd7; awsize = 3'd4; awburst = INCR; awvalid = 1'b1;
    n = 0;
    #1;
    while (!awready && n < 200) begin @(negedge clk); #1; n++; end
    if (n >= 200) check("abort_aw_timeout", awready, 1);
    @(posedge clk); #1 awvalid = 1'b0;
    wdata = 128'hdead; wstrb = '1; wvalid = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk) wvalid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    check("midrst_awready", awready, 0);
    check("midrst_bvalid", bvalid, 0);
    check("midrst_wready", wready, 0);
    @(negedge clk);
    check("midrst_awready2", awready, 0);
    check("midrst_bvalid2", bvalid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_awready", awready, 1);
    wq_data.push_back(128'h4444); wq_data.push_back(128'h5555);
    repeat (2) wq_strb.push_back('1);
    do_write(4'd12, 40'h400, 8'd1, 3'd4, INCR);
    do_read(4'd13, 40'h400, 8'd1, 3'd4, INCR, 1'b0);

    // Incrementing read data persists across bursts.
    do_read_inc(8'd3);
    do_read_inc(8'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
